// File: rtl/sccb_write_arbiter.sv
// Round-robin arbiter sharing one SCCB single-register write engine among NUM_REQ requesters.
// Optional build macro SCCB_ARB_PRIORITY_EN gives requester 0 strict priority over the round-robin group.
module sccb_write_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [24*NUM_REQ-1:0]        req_regpair_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    output logic [NUM_REQ-1:0]           req_done_out,
    output logic [NUM_REQ-1:0]           req_error_out,
    output logic                         wr_valid_out,
    input  logic                         wr_ready_in,
    output logic [23:0]                  wr_regpair_out,
    input  logic                         wr_done_in,
    input  logic                         wr_missed_ack_in,
    output logic                         busy_out,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx_out
);

    localparam int unsigned REGPAIR_W = 24;
    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [IDX_W:0]       NUM_REQ_W   = (IDX_W+1)'(NUM_REQ);
    localparam logic [TMR_W-1:0]     TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]     TMR_MAX     = {TMR_W{1'b1}};
    localparam logic [NUM_REQ-1:0]   REQ_ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [REGPAIR_W-1:0] TERMINATOR  = '0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_COMPLETE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       rr_ptr_nxt;
    logic [IDX_W:0]         ptr_inc;
    logic                   err_flag;
    logic [TMR_W-1:0]       timer;
    logic                   timeout_hit;

    logic [NUM_REQ-1:0]     cand_mask;
    logic [IDX_W:0]         cand;
    logic                   found;
    logic [IDX_W-1:0]       pick;
    logic [REGPAIR_W-1:0]   sel_regpair;
    logic                   accept;

    // Rotating search from rr_ptr; the first valid requester at or after the pointer wins.
    always_comb begin : rr_search
        cand_mask = req_valid_in;
        cand      = '0;
        found     = 1'b0;
        pick      = '0;
`ifdef SCCB_ARB_PRIORITY_EN
        cand_mask[0] = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!found && cand_mask[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
`ifdef SCCB_ARB_PRIORITY_EN
        if (req_valid_in[0]) begin
            found = 1'b1;
            pick  = '0;
        end
`endif
    end

    always_comb begin : regpair_mux
        sel_regpair = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                sel_regpair = req_regpair_in[REGPAIR_W*i +: REGPAIR_W];
            end
        end
    end

    assign accept      = (state == ST_IDLE) && found;
    assign timeout_hit = (timer == TMR_LAST);
    assign ptr_inc     = {1'b0, grant_idx_out} + (IDX_W+1)'(1);
    assign rr_ptr_nxt  = (ptr_inc == NUM_REQ_W) ? '0 : ptr_inc[IDX_W-1:0];

    always_ff @(posedge clk_in or negedge rst_n_in) begin : state_reg
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : next_state_logic
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (sel_regpair == TERMINATOR) ? ST_COMPLETE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_ready_in) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (wr_done_in || timeout_hit) begin
                    state_nxt = ST_COMPLETE;
                end
            end
            ST_COMPLETE: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Ready is the accept strobe itself, masked during reset so no requester sees a phantom accept.
    always_comb begin : output_logic
        req_ready_out = '0;
        req_done_out  = '0;
        req_error_out = '0;
        wr_valid_out  = 1'b0;
        busy_out      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept && rst_n_in) begin
                    req_ready_out = REQ_ONE << pick;
                end
            end
            ST_ISSUE: wr_valid_out = 1'b1;
            ST_COMPLETE: begin
                req_done_out = REQ_ONE << grant_idx_out;
                if (err_flag) begin
                    req_error_out = REQ_ONE << grant_idx_out;
                end
            end
            default: ;
        endcase
    end

    // Transaction context: latched regpair, grant, sticky error, wait timer and fairness pointer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin : datapath_regs
        if (!rst_n_in) begin
            rr_ptr         <= '0;
            grant_idx_out  <= '0;
            wr_regpair_out <= '0;
            err_flag       <= 1'b0;
            timer          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_regpair_out <= sel_regpair;
                        grant_idx_out  <= pick;
                        err_flag       <= 1'b0;
                        timer          <= '0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (timer != TMR_MAX) begin
                        timer <= timer + TMR_W'(1);
                    end
                    if (wr_missed_ack_in || (timeout_hit && !wr_done_in)) begin
                        err_flag <= 1'b1;
                    end
                end
                ST_COMPLETE: begin
`ifdef SCCB_ARB_PRIORITY_EN
                    if (grant_idx_out != '0) begin
                        rr_ptr <= rr_ptr_nxt;
                    end
`else
                    rr_ptr <= rr_ptr_nxt;
`endif
                end
                default: ;
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        $onehot0(req_ready_out));
    a_done_onehot: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        $onehot0(req_done_out));
    a_error_with_done: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        (req_error_out & ~req_done_out) == '0);
    a_regpair_stable: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        (wr_valid_out && !wr_ready_in) |=> $stable(wr_regpair_out));

endmodule

// File: doc/sccb_write_arbiter.md
Name: sccb_write_arbiter

Overview:
- Shares one SCCB single-register write engine among NUM_REQ independent requesters, e.g. the boot-table sequencer, the exposure/AWB tuner and a debug poke port.
- Each request carries one 24-bit regpair: {reg_addr[15:0], reg_data[7:0]}.
- The arbiter grants one requester at a time in round-robin order and forwards the regpair over a valid/ready handshake.
- It then holds the grant until the engine reports the bus transaction finished, or a timeout expires, and returns done/error to the winning requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1000000, maximum cycles spent waiting for wr_done_in after the write handshake before aborting with error.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; asynchronous assert, active-low.
- req_valid_in  input  NUM_REQ  per-requester request valid; held until the matching req_ready_out.
- req_regpair_in  input  24*NUM_REQ  requester i regpair at [24*i+23:24*i].
- req_ready_out  output  NUM_REQ  one-hot accept strobe, one cycle.
- req_done_out  output  NUM_REQ  one-hot completion pulse, one cycle.
- req_error_out  output  NUM_REQ  error pulse, coincident with req_done_out (missed ack or timeout).
- wr_valid_out  output  1  regpair valid to the write engine.
- wr_ready_in  input  1  write engine accepts the regpair.
- wr_regpair_out  output  24  latched regpair.
- wr_done_in  input  1  single-cycle pulse: engine finished the bus transaction (STOP sent).
- wr_missed_ack_in  input  1  engine saw a NACK during the current transaction; level or pulse.
- busy_out  output  1  high in any state except IDLE.
- grant_idx_out  output  $clog2(NUM_REQ)  index of the current or last grant.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - state=IDLE, rr_ptr=0, grant_idx_out=0, wr_regpair_out=0, err_flag=0, timer=0.
  - All outputs low.
  - Mid-operation reset drops wr_valid_out immediately; the engine is reset from the same source.
- States: IDLE, ISSUE, WAIT_DONE, COMPLETE.
- IDLE:
  - Search req_valid_in starting at rr_ptr, wrapping modulo NUM_REQ; first set bit g wins.
  - req_ready_out[g] asserted combinationally in the same cycle; that is the accept handshake.
  - On the accept edge: latch regpair g into wr_regpair_out, grant_idx_out<=g, err_flag<=0, timer<=0.
  - If the latched regpair == 24'h000000, go to COMPLETE; it is the table terminator and is never sent on the bus. Otherwise go to ISSUE.
  - No valid requests: stay in IDLE, all strobes low.
- ISSUE:
  - wr_valid_out=1, wr_regpair_out stable.
  - On wr_valid_out && wr_ready_in, go to WAIT_DONE.
  - wr_done_in and wr_missed_ack_in are ignored in this state.
  - No timeout applies in ISSUE; the engine owns back-pressure.
- WAIT_DONE:
  - timer increments every cycle.
  - wr_missed_ack_in high in any cycle sets sticky err_flag.
  - wr_done_in: go to COMPLETE; err_flag also captures a same-cycle wr_missed_ack_in.
  - timer == TIMEOUT_CYCLES-1 without wr_done_in: err_flag<=1, go to COMPLETE.
  - wr_done_in in the same cycle as the timeout: done wins; error only if a missed ack was seen.
- COMPLETE:
  - req_done_out[grant_idx_out]=1 for exactly this cycle; req_error_out[grant_idx_out]=err_flag.
  - rr_ptr<=(grant_idx_out+1) mod NUM_REQ.
  - Next state IDLE.
- Throughput and latency:
  - Minimum accept-to-accept spacing is 4 cycles with an immediate ready and done.
  - Accept to wr_valid_out: 1 cycle.
  - wr_done_in to req_done_out: 1 cycle.
- Fairness:
  - A requester holding req_valid_in high is served within NUM_REQ grants.
  - Requests arriving outside IDLE wait; nothing is queued internally.
- Timer width: $clog2(TIMEOUT_CYCLES)+1 bits, saturating, never wraps.

Optional Feature:
- Macro: SCCB_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority. In IDLE, req_valid_in[0] wins regardless of rr_ptr. The remaining requesters are round-robin among themselves, and rr_ptr is not updated by grants to requester 0.
- Undefined: pure round-robin across all NUM_REQ requesters as above.

Test Plan:
- Single write: req_valid_in=4'b0010, regpair 24'h300812.
  - req_ready_out=4'b0010 the same cycle; wr_valid_out next cycle with 24'h300812.
  - wr_ready_in high and wr_done_in 10 cycles later -> req_done_out=4'b0010 one cycle after wr_done_in, req_error_out=0.
- Round-robin: all four valid continuously with immediate ready and done -> grant order 0,1,2,3,0; accepts 4 cycles apart.
- Missed ack: pulse wr_missed_ack_in in WAIT_DONE, then wr_done_in -> req_done_out and req_error_out both pulse for the granted index.
- Timeout: TIMEOUT_CYCLES=16, no wr_done_in -> COMPLETE exactly 16 cycles after the write handshake, with error; busy_out low the next cycle.
- Terminator: requester 2 sends 24'h000000 -> wr_valid_out never asserts; req_done_out[2] pulses 1 cycle after accept, no error.
- Async reset: assert rst_n_in mid-WAIT_DONE -> all outputs 0 immediately. After release with requester 3 valid, it is granted first (rr_ptr=0 search wraps to 3). With SCCB_ARB_PRIORITY_EN, req 0 and req 3 valid together -> req 0 granted.
